apb_periph_arbiter: RTL and testbench
=====================================

Name: apb_periph_arbiter

Overview:
- Shares the single APB slave port of the peripheral bus between NB_REQ APB requesters, for example the SoC-bus bridge and the debug/JTAG bridge.
- Requester APB transfers are serialised with round-robin fairness and replayed downstream with a clean SETUP/ACCESS sequence.
- A bus timeout returns PSLVERR when no peripheral answers.
- Sits directly in front of the peripheral bus address decoder.

Parameters:
- NB_REQ, 2, number of requester ports (2..8).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout.
- ERR_RDATA, 32'hBADACCE5, PRDATA returned on a timeout abort.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- req_psel_i  in  NB_REQ  per-requester PSEL
- req_penable_i  in  NB_REQ  per-requester PENABLE
- req_pwrite_i  in  NB_REQ  per-requester PWRITE
- req_paddr_i  in  NB_REQ x APB_ADDR_WIDTH  per-requester PADDR
- req_pwdata_i  in  NB_REQ x APB_DATA_WIDTH  per-requester PWDATA
- req_prdata_o  out  NB_REQ x APB_DATA_WIDTH  per-requester PRDATA
- req_pready_o  out  NB_REQ  per-requester PREADY
- req_pslverr_o  out  NB_REQ  per-requester PSLVERR
- apb_psel_o  out  1  downstream PSEL
- apb_penable_o  out  1  downstream PENABLE
- apb_pwrite_o  out  1  downstream PWRITE
- apb_paddr_o  out  APB_ADDR_WIDTH  downstream PADDR
- apb_pwdata_o  out  APB_DATA_WIDTH  downstream PWDATA
- apb_prdata_i  in  APB_DATA_WIDTH  downstream PRDATA
- apb_pready_i  in  1  downstream PREADY
- apb_pslverr_i  in  1  downstream PSLVERR
- timeout_o  out  1  one-cycle pulse on a timeout abort

Behaviour:
- One clock domain. Reset is synchronous and active-low.
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - RR pointer last_q = NB_REQ-1, so requester 0 has priority first.
  - Timeout counter is 0.
- FSM states IDLE, SETUP, ACCESS, RESP; all outputs are registered.
- IDLE:
  - A requester is pending when its req_psel_i=1, regardless of penable.
  - Winner: first pending index scanning last_q+1, last_q+2, ... modulo NB_REQ.
  - On a winner: latch gnt_q, paddr, pwdata and pwrite; set last_q=winner; go to SETUP.
  - With no pending requester, stay in IDLE.
- SETUP: apb_psel_o=1, apb_penable_o=0, latched fields driven; always exactly 1 cycle, then ACCESS.
- ACCESS:
  - apb_psel_o=1, apb_penable_o=1, counter increments each cycle.
  - If apb_pready_i=1: capture prdata/pslverr, drop psel/penable at the next edge, go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: abort. Capture prdata=ERR_RDATA, pslverr=1, pulse timeout_o in the RESP cycle, go to RESP.
  - A pready in the same cycle as expiry wins: a normal response, no timeout.
- RESP:
  - For exactly 1 cycle, req_pready_o[gnt_q]=1, with req_prdata_o[gnt_q] and req_pslverr_o[gnt_q] valid. All other requesters see pready=0.
  - Counter clears; next state is IDLE.
  - Outside RESP, req_prdata_o/req_pslverr_o are 0.
- Latency:
  - Request sampled in IDLE at cycle c → downstream SETUP at c+1, ACCESS at c+2.
  - Downstream pready at cycle k → upstream pready at k+1.
  - Minimum transfer: 4 cycles of which 1 is idle, giving throughput of one transfer per 4 cycles.
- Non-granted requesters are stalled: they hold psel/penable and see pready=0; they are never dropped.
- Upstream fields are latched only at grant. Requester changes after grant are ignored, which is an APB protocol violation on the requester side.
- Back-to-back:
  - After RESP, IDLE re-arbitrates.
  - The requester just served has the lowest priority.
  - A single requester issuing a new SETUP right after RESP is granted again immediately.
- Simultaneous requests from all NB_REQ requesters are served in strict rotation; starvation is impossible.
- Reset mid-transfer: downstream psel/penable are 0 from the next edge; the aborted requester gets no pready.
- Counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1.

Decomposition:
- periph_arb_pkg holds:
  - typedef enum arb_state_e {IDLE, SETUP, ACCESS, RESP};
  - the function rr_next(pending, last), returning the first set bit after last modulo NB_REQ;
  - localparam IDX_W = $clog2(NB_REQ), minimum 1.
- One sub-module is natural: apb_rr_pick, a combinational round-robin picker. Inputs: pending vector and last index. Outputs: valid and winner index. The FSM, latching and timeout stay in apb_periph_arbiter.

Test Plan:
- Single read: req0 reads 0x1A10_1000, slave pready on the 3rd ACCESS cycle with prdata=0x1234_5678 → downstream SETUP at c+1; req_pready_o[0]=1 with 0x1234_5678 and pslverr=0 one cycle after slave pready; total 6 cycles.
- Contention: req0 and req1 both assert psel in the same cycle after reset → req0 is served first, then req1. Then both immediately re-request → order is req0, req1 again (strict alternation over 4 transfers).
- Write error: req1 writes 0xCAFE_F00D to 0x1A10_4000, slave returns pready=1, pslverr=1 → apb_pwdata_o=0xCAFE_F00D throughout SETUP/ACCESS; req_pslverr_o[1]=1 in RESP; timeout_o stays 0.
- Timeout: TIMEOUT_CYCLES=8, slave never readies → exactly 8 ACCESS cycles, then RESP with prdata=0xBADACCE5, pslverr=1, timeout_o=1 for one cycle. With pready in the 8th cycle instead → normal response, timeout_o=0.
- Reset mid-ACCESS: rst_ni=0 for 1 cycle during ACCESS → apb_psel_o=0 next edge; no req_pready_o pulse; the following request from req1 is served normally with priority starting at req0.
- Stall isolation: req1 requests while req0's slave waits 20 cycles → req_pready_o[1] stays 0 throughout; req1's transfer starts exactly 2 cycles after req0's RESP (IDLE, then SETUP).

Source files
------------

// File: rtl/periph_arb_pkg.sv
// Shared types and the round-robin helper for the APB peripheral-bus arbiter.
package periph_arb_pkg;

  // Index width covers the largest supported requester count (8).
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = (MAX_REQ > 1) ? $clog2(MAX_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} arb_state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of pending after 'last', wrapping modulo nb.
  function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] pending,
                                       input logic [IDX_W-1:0]   last,
                                       input int                 nb);
    rr_pick_t r;
    int       c;
    r = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      c = (int'(last) + i) % nb;
      if (i <= nb && !r.vld && pending[IDX_W'(c)]) begin
        r.vld = 1'b1;
        r.idx = IDX_W'(c);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: winner is the first pending index after last_i.
module apb_rr_pick
  import periph_arb_pkg::*;
#(
  parameter int NB_REQ = 2
) (
  input  logic [NB_REQ-1:0] pending_i,
  input  logic [IDX_W-1:0]  last_i,
  output logic              valid_o,
  output logic [IDX_W-1:0]  idx_o
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_next(MAX_REQ'(pending_i), last_i, NB_REQ);
    valid_o = pick.vld;
    idx_o   = pick.idx;
  end

endmodule

// File: rtl/apb_periph_arbiter.sv
// Serialises NB_REQ APB requesters onto one downstream APB port with round-robin
// fairness, registered outputs and an optional ACCESS-phase timeout.
module apb_periph_arbiter
  import periph_arb_pkg::*;
#(
  parameter int                        NB_REQ         = 2,
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        TIMEOUT_CYCLES = 256,
  parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA      = 32'hBADACCE5
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NB_REQ-1:0]                       req_psel_i,
  input  logic [NB_REQ-1:0]                       req_penable_i,
  input  logic [NB_REQ-1:0]                       req_pwrite_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]   req_paddr_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]   req_pwdata_i,
  output logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]   req_prdata_o,
  output logic [NB_REQ-1:0]                       req_pready_o,
  output logic [NB_REQ-1:0]                       req_pslverr_o,
  output logic                                    apb_psel_o,
  output logic                                    apb_penable_o,
  output logic                                    apb_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]               apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]               apb_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]               apb_prdata_i,
  input  logic                                    apb_pready_i,
  input  logic                                    apb_pslverr_i,
  output logic                                    timeout_o
);

  localparam int               CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e                              state_q, state_d;
  logic [IDX_W-1:0]                        gnt_q, gnt_d, last_q, last_d;
  logic [APB_ADDR_WIDTH-1:0]               paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0]               pwdata_q, pwdata_d;
  logic                                    pwrite_q, pwrite_d;
  logic                                    psel_q, psel_d, penable_q, penable_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [NB_REQ-1:0]                       rdy_q, rdy_d, err_q, err_d;
  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                                    timeout_q, timeout_d;
  logic                                    pick_vld, expired;
  logic [IDX_W-1:0]                        pick_idx;

  // Pending is psel alone; penable is not needed to detect a request.
  logic unused_penable;
  assign unused_penable = ^req_penable_i;

  apb_rr_pick #(.NB_REQ(NB_REQ)) u_pick (
    .pending_i (req_psel_i),
    .last_i    (last_q),
    .valid_o   (pick_vld),
    .idx_o     (pick_idx)
  );

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    cnt_d     = cnt_q;
    rdy_d     = '0;
    err_d     = '0;
    rdata_d   = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: if (pick_vld) begin
        for (int i = 0; i < NB_REQ; i++) begin
          if (pick_idx == IDX_W'(i)) begin
            paddr_d  = req_paddr_i[i];
            pwdata_d = req_pwdata_i[i];
            pwrite_d = req_pwrite_i[i];
          end
        end
        gnt_d   = pick_idx;
        last_d  = pick_idx;
        psel_d  = 1'b1;
        state_d = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // A ready slave in the expiry cycle still gets a normal response.
        if (apb_pready_i || expired) begin
          for (int i = 0; i < NB_REQ; i++) begin
            if (gnt_q == IDX_W'(i)) begin
              rdy_d[i]   = 1'b1;
              rdata_d[i] = apb_pready_i ? apb_prdata_i : ERR_RDATA;
              err_d[i]   = apb_pready_i ? apb_pslverr_i : 1'b1;
            end
          end
          timeout_d = !apb_pready_i;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= IDX_W'(NB_REQ - 1);
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      cnt_q     <= '0;
      rdy_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;
  assign req_pready_o  = rdy_q;
  assign req_pslverr_o = err_q;
  assign req_prdata_o  = rdata_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_apb_periph_arbiter.sv
// Directed bench: a per-cycle vector table for basic transfers plus hand sequences
// for arbitration, timeout, reset and stall corners.
module tb_apb_periph_arbiter;

  localparam logic [31:0] A0  = 32'h1A10_1000;
  localparam logic [31:0] A1  = 32'h1A10_4000;
  localparam logic [31:0] WD1 = 32'hCAFE_F00D;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [1:0]       req_psel, req_penable, req_pwrite;
  logic [1:0][31:0] req_paddr, req_pwdata;
  logic             sl_rdy, sl_err;
  logic [31:0]      sl_rdata;

  logic             a_psel, a_pen, a_pwrite, a_to;
  logic [31:0]      a_paddr, a_pwdata;
  logic [1:0]       a_rdy, a_err;
  logic [1:0][31:0] a_rdata;
  logic             b_psel, b_pen, b_to, unused_b_pwrite;
  logic [31:0]      unused_b_paddr, unused_b_pwdata;
  logic [1:0]       b_rdy, b_err;
  logic [1:0][31:0] b_rdata;

  logic             use_long = 1'b0;
  logic             o_psel, o_pen, o_to;
  logic [1:0]       o_rdy, o_err;
  logic [1:0][31:0] o_rdata;

  int errors = 0;
  int checks = 0;

  assign req_penable = req_psel;
  assign o_psel  = use_long ? b_psel  : a_psel;
  assign o_pen   = use_long ? b_pen   : a_pen;
  assign o_to    = use_long ? b_to    : a_to;
  assign o_rdy   = use_long ? b_rdy   : a_rdy;
  assign o_err   = use_long ? b_err   : a_err;
  assign o_rdata = use_long ? b_rdata : a_rdata;

  apb_periph_arbiter #(.NB_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_psel_i(req_psel), .req_penable_i(req_penable), .req_pwrite_i(req_pwrite),
    .req_paddr_i(req_paddr), .req_pwdata_i(req_pwdata),
    .req_prdata_o(a_rdata), .req_pready_o(a_rdy), .req_pslverr_o(a_err),
    .apb_psel_o(a_psel), .apb_penable_o(a_pen), .apb_pwrite_o(a_pwrite),
    .apb_paddr_o(a_paddr), .apb_pwdata_o(a_pwdata),
    .apb_prdata_i(sl_rdata), .apb_pready_i(sl_rdy), .apb_pslverr_i(sl_err),
    .timeout_o(a_to)
  );

  // Timeout disabled: used for the long-wait stall scenario.
  apb_periph_arbiter #(.NB_REQ(2), .TIMEOUT_CYCLES(0)) dut_long (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_psel_i(req_psel), .req_penable_i(req_penable), .req_pwrite_i(req_pwrite),
    .req_paddr_i(req_paddr), .req_pwdata_i(req_pwdata),
    .req_prdata_o(b_rdata), .req_pready_o(b_rdy), .req_pslverr_o(b_err),
    .apb_psel_o(b_psel), .apb_penable_o(b_pen), .apb_pwrite_o(unused_b_pwrite),
    .apb_paddr_o(unused_b_paddr), .apb_pwdata_o(unused_b_pwdata),
    .apb_prdata_i(sl_rdata), .apb_pready_i(sl_rdy), .apb_pslverr_i(sl_err),
    .timeout_o(b_to)
  );

  typedef struct {
    logic [1:0]  psel;
    logic        rdy, err;
    logic [31:0] rdata;
    logic        e_sel, e_en, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_rdy;
    logic [31:0] e_rd;
    logic        e_err, e_to;
  } vec_t;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rst();
    rst_ni   = 1'b0;
    req_psel = 2'b00;
    sl_rdy   = 1'b0;
    sl_err   = 1'b0;
    sl_rdata = '0;
    repeat (2) step();
    rst_ni = 1'b1;
  endtask

  // Runs one transfer; the slave readies on ACCESS cycle rdy_at (0 = never).
  task automatic xfer(input logic [1:0] sel, input int rdy_at, input logic err,
                      input logic [31:0] rd, output int n_acc, output int n_to,
                      output logic [1:0] rsp, output logic [63:0] rdat,
                      output logic [1:0] rerr);
    n_acc = 0; n_to = 0; rsp = '0; rdat = '0; rerr = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      req_psel = sel;
      sl_err   = err;
      sl_rdata = rd;
      if (o_psel && o_pen) n_acc++;
      sl_rdy = o_psel && o_pen && (n_acc == rdy_at);
      if (o_to) n_to++;
      if (o_rdy != 2'b00) begin
        rsp = o_rdy; rdat = o_rdata; rerr = o_err;
        req_psel = 2'b00; sl_rdy = 1'b0;
        step();
        if (o_to) n_to++;
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("FAIL xfer_bound: got no pready within 60 cycles, expected a response");
  endtask

  initial begin
    vec_t             tbl[12];
    logic [1:0][31:0] exp_rd;
    logic [1:0]       exp_er;
    int               nacc, nto, n, last_cyc, wt, seen, r0, s1, r1, nacc0, acc, bad;
    logic [1:0]       rsp, rerr;
    logic [63:0]      rdat, rd1;

    tbl[0]  = '{2'b01, 0, 0, 32'h0,         0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0,         0, 0};
    tbl[1]  = '{2'b01, 0, 0, 32'h0,         1, 0, 0, A0,    32'h0, 2'b00, 32'h0,         0, 0};
    tbl[2]  = '{2'b01, 0, 0, 32'h0,         1, 1, 0, A0,    32'h0, 2'b00, 32'h0,         0, 0};
    tbl[3]  = '{2'b01, 0, 0, 32'h0,         1, 1, 0, A0,    32'h0, 2'b00, 32'h0,         0, 0};
    tbl[4]  = '{2'b01, 1, 0, 32'h1234_5678, 1, 1, 0, A0,    32'h0, 2'b00, 32'h0,         0, 0};
    tbl[5]  = '{2'b01, 0, 0, 32'h0,         0, 0, 0, 32'h0, 32'h0, 2'b01, 32'h1234_5678, 0, 0};
    tbl[6]  = '{2'b00, 0, 0, 32'h0,         0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0,         0, 0};
    tbl[7]  = '{2'b10, 0, 0, 32'h0,         0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0,         0, 0};
    tbl[8]  = '{2'b10, 0, 0, 32'h0,         1, 0, 1, A1,    WD1,   2'b00, 32'h0,         0, 0};
    tbl[9]  = '{2'b10, 1, 1, 32'h0,         1, 1, 1, A1,    WD1,   2'b00, 32'h0,         0, 0};
    tbl[10] = '{2'b10, 0, 0, 32'h0,         0, 0, 0, 32'h0, 32'h0, 2'b10, 32'h0,         1, 0};
    tbl[11] = '{2'b00, 0, 0, 32'h0,         0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0,         0, 0};

    req_paddr[0] = A0; req_paddr[1] = A1;
    req_pwdata[0] = 32'h0; req_pwdata[1] = WD1;
    req_pwrite = 2'b10;

    // Reset state
    rst();
    chk("rst_psel", a_psel, 0);
    chk("rst_penable", a_pen, 0);
    chk("rst_paddr", a_paddr, 0);
    chk("rst_pready", a_rdy, 0);
    chk("rst_prdata", a_rdata, 0);
    chk("rst_timeout", a_to, 0);

    // Single read (3-cycle slave wait) followed by a write with slave error
    for (int r = 0; r < 12; r++) begin
      req_psel = tbl[r].psel;
      sl_rdy   = tbl[r].rdy;
      sl_err   = tbl[r].err;
      sl_rdata = tbl[r].rdata;
      exp_rd = '0;
      exp_er = '0;
      for (int i = 0; i < 2; i++) begin
        if (tbl[r].e_rdy[i]) begin
          exp_rd[i] = tbl[r].e_rd;
          exp_er[i] = tbl[r].e_err;
        end
      end
      chk($sformatf("row%0d_psel", r), a_psel, tbl[r].e_sel);
      chk($sformatf("row%0d_penable", r), a_pen, tbl[r].e_en);
      chk($sformatf("row%0d_pready", r), a_rdy, tbl[r].e_rdy);
      chk($sformatf("row%0d_prdata", r), a_rdata, exp_rd);
      chk($sformatf("row%0d_pslverr", r), a_err, exp_er);
      chk($sformatf("row%0d_timeout", r), a_to, tbl[r].e_to);
      if (tbl[r].e_sel) begin
        chk($sformatf("row%0d_paddr", r), a_paddr, tbl[r].e_addr);
        chk($sformatf("row%0d_pwdata", r), a_pwdata, tbl[r].e_wdata);
        chk($sformatf("row%0d_pwrite", r), a_pwrite, tbl[r].e_wr);
      end
      step();
    end

    // Contention: both requesters continuously, slave ready at once
    rst();
    req_psel = 2'b11;
    n = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      sl_rdy = a_psel && a_pen;
      if (a_rdy != 2'b00) begin
        chk($sformatf("rr_order%0d", n), a_rdy, (n % 2 == 0) ? 2'b01 : 2'b10);
        if (n > 0) chk($sformatf("rr_interval%0d", n), cyc - last_cyc, 4);
        last_cyc = cyc;
        n++;
      end
      step();
    end
    chk("rr_count", n, 4);

    // Timeout: slave never ready
    rst();
    xfer(2'b01, 0, 1'b0, 32'h0, nacc, nto, rsp, rdat, rerr);
    chk("to_access_cycles", nacc, 8);
    chk("to_pulses", nto, 1);
    chk("to_pready", rsp, 2'b01);
    chk("to_prdata", rdat, {32'h0, 32'hBADA_CCE5});
    chk("to_pslverr", rerr, 2'b01);

    // Ready on the 8th ACCESS cycle wins over expiry
    xfer(2'b01, 8, 1'b0, 32'h0000_8888, nacc, nto, rsp, rdat, rerr);
    chk("edge_access_cycles", nacc, 8);
    chk("edge_pulses", nto, 0);
    chk("edge_prdata", rdat, {32'h0, 32'h0000_8888});
    chk("edge_pslverr", rerr, 2'b00);

    // Reset during ACCESS
    rst();
    req_psel = 2'b01;
    wt = 0;
    while (!(a_psel && a_pen) && wt < 10) begin
      step();
      wt++;
    end
    chk("mid_reach_access", a_psel && a_pen, 1);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    req_psel = 2'b00;
    chk("mid_psel_drop", a_psel, 0);
    chk("mid_penable_drop", a_pen, 0);
    seen = 0;
    repeat (4) begin
      if (a_rdy != 2'b00) seen++;
      step();
    end
    chk("mid_no_pready", seen, 0);
    xfer(2'b10, 1, 1'b0, 32'h0000_0077, nacc, nto, rsp, rdat, rerr);
    chk("mid_req1_pready", rsp, 2'b10);
    chk("mid_req1_prdata", rdat, {32'h0000_0077, 32'h0});

    // Stall isolation on the no-timeout instance: req0 slave waits 20 cycles
    rst();
    use_long = 1'b1;
    r0 = -1; s1 = -1; r1 = -1; acc = 0; nacc0 = 0; bad = 0; nto = 0; rd1 = '0;
    for (int cyc = 0; cyc < 80 && r1 < 0; cyc++) begin
      req_psel = {(cyc >= 2) && (r1 < 0), r0 < 0};
      sl_rdata = (r0 < 0) ? 32'h1111_0000 : 32'h5555_AAAA;
      sl_err   = 1'b0;
      if (o_psel && o_pen) acc++;
      sl_rdy = o_psel && o_pen && (acc == ((r0 < 0) ? 20 : 1));
      if (o_to) nto++;
      if (r0 >= 0 && s1 < 0 && o_psel) s1 = cyc;
      if (o_rdy[1] && r0 < 0) bad++;
      if (o_rdy[0]) begin
        r0 = cyc;
        nacc0 = acc;
        acc = 0;
      end
      if (o_rdy[1]) begin
        r1 = cyc;
        rd1 = o_rdata;
      end
      step();
    end
    req_psel = 2'b00;
    sl_rdy = 1'b0;
    chk("stall_req1_early", bad, 0);
    chk("stall_req0_access", nacc0, 20);
    chk("stall_gap", s1 - r0, 2);
    chk("stall_req1_done", r1 >= 0, 1);
    chk("stall_req1_prdata", rd1, {32'h5555_AAAA, 32'h0});
    chk("stall_no_timeout", nto, 0);
    use_long = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
